// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and position type used by vga_timing and its axis counters.
package vga_pkg;
   localparam int POS_W     = 10;
   localparam int MAX_TOTAL = 1 << POS_W;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef logic [POS_W-1:0] pos_t;

   // Half-open window test done in int so an upper bound of 1024 still fits.
   function automatic logic in_window(input pos_t pos, input int lo, input int hi);
      return (int'(pos) >= lo) && (int'(pos) < hi);
   endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter with enable; resets to its terminal value so the
// first enabled edge lands on 0. next_o exposes the value the counter will take.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int MAX = 799
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output pos_t count_o,
   output pos_t next_o,
   output logic tc_o
);
   localparam pos_t MAX_V = pos_t'(MAX);

   pos_t count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = tc_o ? '0 : count_q + pos_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) count_q <= MAX_V;
      else       count_q <= count_d;
   end

   assign tc_o    = (count_q == MAX_V);
   assign count_o = count_q;
   assign next_o  = count_d;
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Define VGA_PIX_DIV_EN to advance on every
// second clk (internal pixel-enable toggle) instead of every clk.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             hsync,
   output logic             vsync,
   output logic             active,
   output logic             line_start,
   output logic             frame_start,
   output logic             pix_en
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_cfg_err
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
   end

`ifdef VGA_PIX_DIV_EN
   logic pix_en_q;

   always_ff @(posedge clk) begin
      if (rst) pix_en_q <= 1'b0;
      else     pix_en_q <= ~pix_en_q;
   end

   assign pix_en = pix_en_q;
`else
   assign pix_en = 1'b1;
`endif

   pos_t h_count, h_next, v_count, v_next;
   logic h_tc, v_tc;

   vga_axis_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (pix_en),
      .count_o (h_count),
      .next_o  (h_next),
      .tc_o    (h_tc)
   );

   vga_axis_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (pix_en & h_tc),
      .count_o (v_count),
      .next_o  (v_next),
      .tc_o    (v_tc)
   );

   logic hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
   logic hsync_d, vsync_d, active_d, line_start_d, frame_start_d;

   // Decoded from the counters' next values so the flags line up with hpos/vpos.
   always_comb begin
      hsync_d       = ~in_window(h_next, HS_START, HS_START + H_SYNC);
      vsync_d       = ~in_window(v_next, VS_START, VS_START + V_SYNC);
      active_d      = in_window(h_next, 0, H_ACTIVE) & in_window(v_next, 0, V_ACTIVE);
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
      if (pix_en) begin
         line_start_d  = h_tc;
         frame_start_d = h_tc & v_tc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hpos        = h_count;
   assign vpos        = v_count;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign active      = active_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size and small-size instances checked against a
// pixel-index reference model, a vector table and hand-written line/frame sequences.
module tb_vga_timing;
`ifdef VGA_PIX_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int DIV = DIV_EN ? 2 : 1;

   localparam int D_HT = 800, D_VT = 525, D_TOT = D_HT * D_VT;
   localparam int S_HT = 14,  S_VT = 7,   S_TOT = S_HT * S_VT;

   logic clk;
   logic rst_def, rst_small;
   logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
   logic d_hsync, d_vsync, d_active, d_ls, d_fs, d_pe;
   logic s_hsync, s_vsync, s_active, s_ls, s_fs, s_pe;

   int tests_run = 0;
   int failed    = 0;
   bit chk_en    = 1'b0;

   vga_timing dut_def (
      .clk(clk), .rst(rst_def), .hpos(d_hpos), .vpos(d_vpos),
      .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
      .line_start(d_ls), .frame_start(d_fs), .pix_en(d_pe)
   );

   vga_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_small (
      .clk(clk), .rst(rst_small), .hpos(s_hpos), .vpos(s_vpos),
      .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
      .line_start(s_ls), .frame_start(s_fs), .pix_en(s_pe)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   // State is just the linear pixel index within the frame plus the pixel-enable phase.
   int n_def = D_TOT - 1, n_small = S_TOT - 1;
   bit pe_def = 1'b1, pe_small = 1'b1;

   always @(posedge clk) begin
      if (rst_def) begin
         n_def  = D_TOT - 1;
         pe_def = !DIV_EN;
      end else begin
         if (pe_def) n_def = (n_def + 1) % D_TOT;
         if (DIV_EN) pe_def = !pe_def;
      end
      if (rst_small) begin
         n_small  = S_TOT - 1;
         pe_small = !DIV_EN;
      end else begin
         if (pe_small) n_small = (n_small + 1) % S_TOT;
         if (DIV_EN) pe_small = !pe_small;
      end
   end

   function automatic logic [25:0] model_vec(input int n, input int ha, input int hf,
                                             input int hs, input int hb, input int va,
                                             input int vf, input int vs, input bit pe);
      int ht, h, v;
      logic [9:0] hv, vv;
      logic hsy, vsy, act;
      ht  = ha + hf + hs + hb;
      h   = n % ht;
      v   = n / ht;
      hv  = h[9:0];
      vv  = v[9:0];
      hsy = !((h >= ha + hf) && (h < ha + hf + hs));
      vsy = !((v >= va + vf) && (v < va + vf + vs));
      act = (h < ha) && (v < va);
      return {hv, vv, hsy, vsy, act, (h == 0), (n == 0), pe};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("def_cycle",
               {6'b0, d_hpos, d_vpos, d_hsync, d_vsync, d_active, d_ls, d_fs, d_pe},
               {6'b0, model_vec(n_def, 640, 16, 96, 48, 480, 10, 2, pe_def)});
         check("small_cycle",
               {6'b0, s_hpos, s_vpos, s_hsync, s_vsync, s_active, s_ls, s_fs, s_pe},
               {6'b0, model_vec(n_small, 8, 2, 2, 2, 4, 1, 1, pe_small)});
      end
   end

   // ---------------- vector table (small instance) ----------------
   typedef struct {
      bit do_rst;
      int adv;
      int h;
      int v;
      bit hs, vs, act, ls, fs;
   } vec_t;

   vec_t vecs[17];

   // ---------------- driver tasks ----------------
   task automatic pulse_rst_small();
      rst_small = 1'b1;
      @(negedge clk);
      rst_small = 1'b0;
   endtask

   task automatic pulse_rst_def();
      rst_def = 1'b1;
      @(negedge clk);
      rst_def = 1'b0;
   endtask

   initial begin
      logic [9:0] eh, ev;
      int hs_cnt, hs_first, hs_last, act_fall, ls_rise0, ls_rise1, waited;
      int fs_rise0, fs_rise1, vs_cnt;
      logic prev_act, prev_ls, prev_fs;

      rst_def   = 1'b1;
      rst_small = 1'b1;
      @(negedge clk);
      rst_def   = 1'b0;
      rst_small = 1'b0;
      chk_en    = 1'b1;

      vecs[0]  = '{1, 0,  13, 6, 1, 1, 0, 0, 0};
      vecs[1]  = '{0, 1,  0,  0, 1, 1, 1, 1, 1};
      vecs[2]  = '{0, 1,  1,  0, 1, 1, 1, 0, 0};
      vecs[3]  = '{0, 7,  8,  0, 1, 1, 0, 0, 0};
      vecs[4]  = '{0, 2,  10, 0, 0, 1, 0, 0, 0};
      vecs[5]  = '{0, 1,  11, 0, 0, 1, 0, 0, 0};
      vecs[6]  = '{0, 1,  12, 0, 1, 1, 0, 0, 0};
      vecs[7]  = '{0, 1,  13, 0, 1, 1, 0, 0, 0};
      vecs[8]  = '{0, 1,  0,  1, 1, 1, 1, 1, 0};
      vecs[9]  = '{0, 56, 0,  5, 1, 0, 0, 1, 0};
      vecs[10] = '{0, 13, 13, 5, 1, 0, 0, 0, 0};
      vecs[11] = '{0, 1,  0,  6, 1, 1, 0, 1, 0};
      vecs[12] = '{0, 13, 13, 6, 1, 1, 0, 0, 0};
      vecs[13] = '{0, 1,  0,  0, 1, 1, 1, 1, 1};
      vecs[14] = '{0, 80, 10, 5, 0, 0, 0, 0, 0};
      vecs[15] = '{1, 0,  13, 6, 1, 1, 0, 0, 0};
      vecs[16] = '{0, 1,  0,  0, 1, 1, 1, 1, 1};

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].do_rst) pulse_rst_small();
         repeat (vecs[i].adv * DIV) @(negedge clk);
         eh = vecs[i].h[9:0];
         ev = vecs[i].v[9:0];
         check($sformatf("vec%0d", i),
               {7'b0, s_hpos, s_vpos, s_hsync, s_vsync, s_active, s_ls, s_fs},
               {7'b0, eh, ev, vecs[i].hs, vecs[i].vs, vecs[i].act, vecs[i].ls, vecs[i].fs});
      end

      // Default instance: one line of hsync / active / line_start timing.
      pulse_rst_def();
      hs_cnt = 0; hs_first = -1; hs_last = -1; act_fall = -1;
      ls_rise0 = -1; ls_rise1 = -1;
      prev_act = d_active; prev_ls = d_ls;
      for (int c = 0; c < 2 * D_HT * DIV + 4; c++) begin
         @(negedge clk);
         if (d_vpos == 10'd0 && !d_hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(d_hpos);
            hs_last = int'(d_hpos);
         end
         if (prev_act && !d_active && act_fall < 0) act_fall = int'(d_hpos);
         if (d_ls && !prev_ls) begin
            if (ls_rise0 < 0) ls_rise0 = c;
            else if (ls_rise1 < 0) ls_rise1 = c;
         end
         prev_act = d_active;
         prev_ls  = d_ls;
      end
      check("hsync_first", hs_first, 656);
      check("hsync_last", hs_last, 751);
      check("hsync_width", hs_cnt, 96 * DIV);
      check("active_fall", act_fall, 640);
      check("line_period", ls_rise1 - ls_rise0, D_HT * DIV);

      // Default instance: reset mid-line, then resume at the origin.
      waited = 0;
      while (d_hpos != 10'd700 && waited < 2 * D_HT * DIV) begin
         @(negedge clk);
         waited++;
      end
      check("reach_h700", {22'b0, d_hpos}, 32'd700);
      pulse_rst_def();
      check("mid_rst_vals", {10'b0, d_hpos, d_vpos, d_hsync, d_vsync},
            {10'b0, 10'd799, 10'd524, 1'b1, 1'b1});
      repeat (DIV) @(negedge clk);
      check("mid_rst_resume", {10'b0, d_hpos, d_vpos, d_active, d_fs},
            {10'b0, 10'd0, 10'd0, 1'b1, 1'b1});

      // Small instance: frame period and vsync width across two frames.
      pulse_rst_small();
      vs_cnt = 0; fs_rise0 = -1; fs_rise1 = -1; prev_fs = s_fs;
      for (int c = 0; c < 2 * S_TOT * DIV + 4; c++) begin
         @(negedge clk);
         if (fs_rise0 >= 0 && fs_rise1 < 0 && !s_vsync) vs_cnt++;
         if (s_fs && !prev_fs) begin
            if (fs_rise0 < 0) fs_rise0 = c;
            else if (fs_rise1 < 0) fs_rise1 = c;
         end
         prev_fs = s_fs;
      end
      check("frame_period", fs_rise1 - fs_rise0, S_TOT * DIV);
      check("vsync_width", vs_cnt, S_HT * DIV);

      // Randomised resets on both instances, checked cycle by cycle by the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst_small = ($urandom_range(0, 149) == 0);
         rst_def   = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
      rst_small = 1'b0;
      rst_def   = 1'b0;
      repeat (4) @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
